// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond: synchronises and debounces the raw car sensors and parade/return
// buttons feeding the traffic-light FSM. Sensors become clean levels; buttons become
// single-cycle pulses on their debounced rising edge, with return taking priority.
// Define TSC_GLITCH_CNT_EN to add o_glitch_cnt, a saturating count of debounce aborts.
module traffic_sensor_cond #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_raw_t_a,
    input  logic       i_raw_t_b,
    input  logic       i_raw_p,
    input  logic       i_raw_r,
    output logic       o_t_a,
    output logic       o_t_b,
    output logic       o_p,
    output logic       o_r
`ifdef TSC_GLITCH_CNT_EN
    ,
    output logic [7:0] o_glitch_cnt
`endif
);
    typedef enum logic [1:0] {S_LO, S_CHK_HI, S_HI, S_CHK_LO} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    // Channel order everywhere: 0=t_a, 1=t_b, 2=p, 3=r
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] lvl_w;
    logic [1:0] btn_q;
`ifdef TSC_GLITCH_CNT_EN
    logic [3:0] abort_w;
    logic [8:0] glitch_d;
`endif

    // Two-flop synchronisers for all four raw inputs
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {i_raw_r, i_raw_p, i_raw_t_b, i_raw_t_a};
            sync2_q <= sync1_q;
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_ch
        state_t           st_q;
        logic [CNT_W-1:0] cnt_q;
        // Debounce FSM: the level flips only after DEB_CYCLES agreeing synchronised samples
        always_ff @(posedge i_clk) begin
            if (!i_rstn) begin
                st_q  <= S_LO;
                cnt_q <= '0;
            end else begin
                case (st_q)
                    S_LO: if (sync2_q[c]) begin
                        st_q  <= (DEB_CYCLES == 1) ? S_HI : S_CHK_HI;
                        cnt_q <= (DEB_CYCLES == 1) ? '0 : ONE;
                    end
                    S_CHK_HI: if (!sync2_q[c]) begin
                        st_q  <= S_LO;
                        cnt_q <= '0;
                    end else if (cnt_q == LAST) begin
                        st_q  <= S_HI;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                    S_HI: if (!sync2_q[c]) begin
                        st_q  <= (DEB_CYCLES == 1) ? S_LO : S_CHK_LO;
                        cnt_q <= (DEB_CYCLES == 1) ? '0 : ONE;
                    end
                    S_CHK_LO: if (sync2_q[c]) begin
                        st_q  <= S_HI;
                        cnt_q <= '0;
                    end else if (cnt_q == LAST) begin
                        st_q  <= S_LO;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                    default: begin
                        st_q  <= S_LO;
                        cnt_q <= '0;
                    end
                endcase
            end
        end
        assign lvl_w[c] = (st_q == S_HI) || (st_q == S_CHK_LO);
`ifdef TSC_GLITCH_CNT_EN
        assign abort_w[c] = ((st_q == S_CHK_HI) && !sync2_q[c]) || ((st_q == S_CHK_LO) && sync2_q[c]);
`endif
    end

    // Previous debounced button levels, used to turn a rising level into one pulse
    always_ff @(posedge i_clk) begin
        if (!i_rstn) btn_q <= '0;
        else         btn_q <= lvl_w[3:2];
    end

    assign o_t_a = lvl_w[0];
    assign o_t_b = lvl_w[1];
    assign o_r   = lvl_w[3] & ~btn_q[1];
    assign o_p   = lvl_w[2] & ~btn_q[0] & ~o_r;

`ifdef TSC_GLITCH_CNT_EN
    assign glitch_d = {1'b0, o_glitch_cnt} + 9'(abort_w[0]) + 9'(abort_w[1])
                    + 9'(abort_w[2]) + 9'(abort_w[3]);

    // Saturating count of aborted debounce attempts across all channels
    always_ff @(posedge i_clk) begin
        if (!i_rstn) o_glitch_cnt <= '0;
        else         o_glitch_cnt <= glitch_d[8] ? 8'hFF : glitch_d[7:0];
    end
`endif
endmodule

// File: tb/tb_traffic_sensor_cond.sv
// tb_traffic_sensor_cond: directed and random stimulus checked against a run-length
// debounce model; TSC_GLITCH_CNT_EN also checks the abort counter.
module tb_traffic_sensor_cond;
    localparam int DEB = 4;

    logic i_clk = 1'b0;
    logic i_rstn = 1'b0;
    logic i_raw_t_a = 1'b0, i_raw_t_b = 1'b0, i_raw_p = 1'b0, i_raw_r = 1'b0;
    logic o_t_a, o_t_b, o_p, o_r;
`ifdef TSC_GLITCH_CNT_EN
    logic [7:0] o_glitch_cnt;
`endif

    int checks = 0, errors = 0, step_n = 0;
    int p_cnt = 0, r_cnt = 0;

    // Reference model: raw delayed by two samples, level flips after DEB disagreeing samples
    bit [3:0] m_s1, m_s2, m_lvl;
    int       m_run [4];
    bit       m_p, m_r;
    int       m_glitch;

    traffic_sensor_cond #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_raw_t_a(i_raw_t_a), .i_raw_t_b(i_raw_t_b), .i_raw_p(i_raw_p), .i_raw_r(i_raw_r),
        .o_t_a(o_t_a), .o_t_b(o_t_b), .o_p(o_p), .o_r(o_r)
`ifdef TSC_GLITCH_CNT_EN
        , .o_glitch_cnt(o_glitch_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    function automatic void model_edge(input bit rstn, input bit [3:0] raw);
        bit [3:0] rose = '0;
        int ab = 0;
        if (!rstn) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_p = 0; m_r = 0; m_glitch = 0;
            for (int c = 0; c < 4; c++) m_run[c] = 0;
            return;
        end
        for (int c = 0; c < 4; c++) begin
            if (m_s2[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    m_lvl[c] = ~m_lvl[c];
                    m_run[c] = 0;
                    rose[c]  = m_lvl[c];
                end
            end else begin
                if (m_run[c] > 0) ab++;
                m_run[c] = 0;
            end
        end
        m_r = rose[3];
        m_p = rose[2] && !rose[3];
        m_glitch = (m_glitch + ab > 255) ? 255 : m_glitch + ab;
        m_s2 = m_s1;
        m_s1 = raw;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s step=%0d got=%0d exp=%0d", tag, step_n, got, exp);
        end
    endtask

    task automatic step(input bit rstn, input bit [3:0] raw);
        {i_raw_r, i_raw_p, i_raw_t_b, i_raw_t_a} = raw;
        i_rstn = rstn;
        @(posedge i_clk);
        model_edge(rstn, raw);
        step_n++;
        @(negedge i_clk);
        chk("t_a", o_t_a, m_lvl[0]);
        chk("t_b", o_t_b, m_lvl[1]);
        chk("p", o_p, m_p);
        chk("r", o_r, m_r);
`ifdef TSC_GLITCH_CNT_EN
        chk("glitch", o_glitch_cnt, m_glitch);
`endif
        p_cnt += int'(o_p);
        r_cnt += int'(o_r);
    endtask

    initial begin
        int first;
        bit [3:0] raw;
        // Reset then idle
        repeat (20) step(0, 4'b0000);
        repeat (5) step(1, 4'b0000);
        // Clean press and release on street A
        p_cnt = 0; r_cnt = 0; first = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1, 4'b0001);
            if (o_t_a && first == 0) first = k;
        end
        chk("lat_rise", first, 6);
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1, 4'b0000);
            if (!o_t_a && first == 0) first = k;
        end
        chk("lat_fall", first, 6);
        chk("pr_quiet", p_cnt + r_cnt, 0);
        // Bouncing parade button, then held
        p_cnt = 0; first = 0;
        for (int i = 0; i < 20; i++) step(1, ((i / 2) % 2 == 0) ? 4'b0100 : 4'b0000);
        for (int k = 1; k <= 12; k++) begin
            step(1, 4'b0100);
            if (o_p && first == 0) first = k;
        end
        chk("bounce_pulses", p_cnt, 1);
        chk("bounce_lat", first, 6);
`ifdef TSC_GLITCH_CNT_EN
        chk("glitch_seen", o_glitch_cnt != 0, 1);
`endif
        repeat (12) step(1, 4'b0000);
        // Hold, release and hold the return button
        r_cnt = 0;
        repeat (100) step(1, 4'b1000);
        repeat (10) step(1, 4'b0000);
        repeat (30) step(1, 4'b1000);
        chk("repeat_pulses", r_cnt, 2);
        repeat (12) step(1, 4'b0000);
        // Parade and return rising together
        p_cnt = 0; r_cnt = 0;
        repeat (20) step(1, 4'b1100);
        chk("simul_r", r_cnt, 1);
        chk("simul_p", p_cnt, 0);
        repeat (12) step(1, 4'b0000);
        // Reset in the middle of a street-B debounce
        step(1, 4'b0010);
        step(1, 4'b0010);
        step(0, 4'b0010);
        step(0, 4'b0010);
        chk("rst_mid_tb", o_t_b, 0);
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1, 4'b0010);
            if (o_t_b && first == 0) first = k;
        end
        chk("rst_mid_lat", first, 6);
        repeat (12) step(1, 4'b0000);
        // Random chatter with occasional resets
        raw = '0;
        repeat (400) begin
            for (int c = 0; c < 4; c++) if ($urandom_range(0, 5) == 0) raw[c] = ~raw[c];
            step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, raw);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/traffic_sensor_cond.md
Name: traffic_sensor_cond

Overview:
- Input conditioning stage directly upstream of the traffic-light FSM.
- Takes raw asynchronous car sensors (street A, street B) and parade/return push-buttons.
- Per channel: synchronise, debounce, then drive the FSM's i_t_a/i_t_b as clean levels and i_p/i_r as single-cycle pulses.
- Prevents metastability, button bounce and sensor chatter from causing spurious light changes.

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronised samples required before a debounced level changes; legal range 1..(2^CNT_W - 1).
- CNT_W, 3: width of each per-channel debounce counter.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rstn  input  1  reset; one clock; reset is synchronous and active-low.
- i_raw_t_a  input  1  raw street-A car sensor, asynchronous.
- i_raw_t_b  input  1  raw street-B car sensor, asynchronous.
- i_raw_p  input  1  raw parade-mode button, asynchronous.
- i_raw_r  input  1  raw return-to-normal button, asynchronous.
- o_t_a  output  1  debounced level, street-A traffic; feeds FSM i_t_a.
- o_t_b  output  1  debounced level, street-B traffic; feeds FSM i_t_b.
- o_p  output  1  one-cycle pulse on debounced rising edge of parade button; feeds FSM i_p.
- o_r  output  1  one-cycle pulse on debounced rising edge of return button; feeds FSM i_r.

Behaviour:
- Reset (i_rstn=0 at a rising edge):
  - All sync flops, counters and debounced levels are cleared to 0.
  - Every channel FSM goes to S_LO; o_t_a=o_t_b=o_p=o_r=0.
  - Reset mid-debounce discards progress; no pulse is emitted on the reset edge.
  - After release, a raw input held high is treated as a new rising edge: full latency applies, pulse is generated.
- Synchroniser: 2 flops per channel (sync1, sync2), all 4 channels identical.
- Channel FSM, 4 states, one per channel; the debounced level is 1 in S_HI and S_CHK_LO:
  - S_LO: sync2=1 -> S_CHK_HI, cnt=1; else stay.
  - S_CHK_HI: sync2=0 -> S_LO, cnt=0 (glitch abort). sync2=1 and cnt==DEB_CYCLES-1 -> S_HI, cnt=0. Else cnt++.
  - S_HI: sync2=0 -> S_CHK_LO, cnt=1.
  - S_CHK_LO: symmetric to S_CHK_HI; return to S_HI on abort, go to S_LO on completion.
  - DEB_CYCLES=1: S_LO goes directly to S_HI on the first sync2=1 sample; CHK states are never entered.
- Counter: never wraps; it is compared against DEB_CYCLES-1 before increment.
- Latency: raw held high from the first sampling edge E1 gives o_t_a=1 after edge E(DEB_CYCLES+2); default is the 6th edge. Falling edge has the same latency.
- o_t_a / o_t_b: registered debounced level.
- o_p / o_r:
  - High for exactly one cycle, in the cycle the channel's debounced level first becomes 1.
  - Holding the button gives no further pulses.
  - Release must complete debounce-low before another pulse is possible.
- Simultaneous events: if o_p and o_r would assert in the same cycle, o_r=1 and o_p=0 (return has priority, so the FSM never sees both).
  - A suppressed p pulse is lost; its level stays high, so no re-pulse occurs until the button is released.
- Pulses are never generated by falling edges.
- All outputs are registered; there is no combinational path from any input to any output.

Optional Feature:
- Macro TSC_GLITCH_CNT_EN.
- Defined:
  - Adds output port o_glitch_cnt [7:0].
  - Counts every abort transition (S_CHK_HI->S_LO or S_CHK_LO->S_HI) across all 4 channels.
  - Multiple aborts in one cycle add their count (0..4).
  - Saturates at 255; reset clears it to 0.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: i_rstn=0 for 20 cycles, all raw inputs 0 -> all outputs 0 throughout and after release.
- Clean press: i_raw_t_a 0->1 and held -> o_t_a=1 after the 6th rising edge (DEB_CYCLES=4). i_raw_t_a 1->0 -> o_t_a=0 after the 6th edge; o_p/o_r remain 0.
- Bounce rejection: i_raw_p toggles every 2 cycles for 20 cycles, then held 1 -> exactly one o_p pulse of 1 cycle, 6 edges after the final rise. With TSC_GLITCH_CNT_EN, o_glitch_cnt>0 and matches the abort count.
- Hold and repeat: i_raw_r held 1 for 100 cycles, released 10 cycles, held again -> exactly 2 o_r pulses, each 1 cycle wide.
- Simultaneous p/r: i_raw_p and i_raw_r rise on the same edge -> o_r=1 for 1 cycle, o_p stays 0, no later o_p while held.
- Reset mid-debounce: i_raw_t_b rises, i_rstn=0 at the 3rd edge for 2 cycles, raw held 1 -> o_t_b=0 through reset, then 1 at the 6th edge after release.
